// File: rtl/sys_gpio_debounce_if.sv
// sys_gpio_debounce_if -- signal bundle between a debounce block and its user.
//   enable      : lets the prescaler and filter counters run (user -> debouncer)
//   raw_in      : asynchronous board-level inputs (user -> debouncer)
//   in_port     : debounced, registered level (debouncer -> user)
//   rise / fall : one-cycle edge pulses per bit (debouncer -> user)
//   sample_tick : one-cycle strobe marking each filter evaluation
interface sys_gpio_debounce_if #(
  parameter int unsigned WIDTH = 32
);
  logic             enable;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] in_port;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             sample_tick;

  modport master (
    output enable, raw_in,
    input  in_port, rise, fall, sample_tick
  );

  modport slave (
    input  enable, raw_in,
    output in_port, rise, fall, sample_tick
  );
endinterface

// File: rtl/sys_gpio_debounce.sv
// sys_gpio_debounce -- synchronizes and debounces WIDTH asynchronous inputs.
// Each bit is sampled once per prescaler tick; a new level is accepted only
// after STABLE_COUNT consecutive ticks that differ from the current level.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : sys_gpio_debounce_if.slave (enable, raw_in, in_port, rise,
//           fall, sample_tick)
module sys_gpio_debounce #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sys_gpio_debounce_if.slave   bus
);

  localparam int unsigned CW = (STABLE_COUNT > 2) ? $clog2(STABLE_COUNT) : 1;
  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [PW-1:0]    presc;
  logic [CW-1:0]    cnt [WIDTH];
  logic             tick;

  // Combinational strobe: true in the cycle the prescaler sits on its last
  // value while enabled, so the filter update lands on the following edge.
  assign tick = bus.enable && !reset && (presc == PRE_LAST);

  // Synchronizer runs regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (bus.enable) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      if (tick) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (sync2[i] == level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            // Edge pulses are registered alongside level so they appear in
            // the same cycle the new level becomes visible.
            level[i]  <= sync2[i];
            rise_q[i] <= sync2[i];
            fall_q[i] <= ~sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign bus.in_port     = level;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign bus.sample_tick = tick;

endmodule

// File: tb/tb_sys_gpio_debounce.sv
module tb_sys_gpio_debounce;

  localparam int unsigned WIDTH        = 32;
  localparam int unsigned PRESCALE     = 4;
  localparam int unsigned STABLE_COUNT = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sys_gpio_debounce_if #(.WIDTH(WIDTH)) bus ();

  sys_gpio_debounce #(
    .WIDTH(WIDTH),
    .PRESCALE(PRESCALE),
    .STABLE_COUNT(STABLE_COUNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the synchronizer is a two-deep delay of raw_in, the
  // sample schedule is "every PRESCALE-th enabled cycle since reset", and
  // each bit keeps a run length of consecutive ticks that disagree with its
  // accepted level; a run reaching STABLE_COUNT flips the level.
  logic [WIDTH-1:0] m_s1, m_s2, m_in, m_rise, m_fall;
  int unsigned      m_en_cycles;
  int               run [WIDTH];
  logic             m_tick_now;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_in = '0; m_rise = '0; m_fall = '0;
      m_en_cycles = 0;
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
    end else begin
      m_tick_now = bus.enable && (m_en_cycles % PRESCALE == PRESCALE - 1);
      m_rise = '0;
      m_fall = '0;
      if (m_tick_now) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (m_s2[i] != m_in[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == STABLE_COUNT) begin
              m_in[i] = m_s2[i];
              if (m_s2[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
      if (bus.enable) m_en_cycles = m_en_cycles + 1;
      m_s2 = m_s1;
      m_s1 = bus.raw_in;
    end
  end

  function automatic logic exp_tick();
    return !reset && bus.enable && (m_en_cycles % PRESCALE == PRESCALE - 1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.raw_in = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== '0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: in_port=%h rise=%h fall=%h tick=%b, expected all 0",
                 k, bus.in_port, bus.rise, bus.fall, bus.sample_tick);
      end
      bus.raw_in = $urandom;
    end
  endtask

  task automatic test_single_bit();
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.raw_in = 32'h1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL single_bit cycle %0d: in_port=%h rise=%h fall=%h tick=%b, expected %h %h %h %b",
                 k, bus.in_port, bus.rise, bus.fall, bus.sample_tick, m_in, m_rise, m_fall, exp_tick());
      end
      if (k == 3) begin
        checks++;
        if (bus.sample_tick !== 1'b1) begin
          errors++;
          $display("FAIL first_tick: sample_tick=%b, expected 1", bus.sample_tick);
        end
      end
      if (k == 11) begin
        checks++;
        if (bus.in_port !== 32'h0) begin
          errors++;
          $display("FAIL single_bit_early: in_port=%h, expected 00000000", bus.in_port);
        end
      end
      if (k == 12) begin
        checks++;
        if (bus.in_port !== 32'h1 || bus.rise !== 32'h1) begin
          errors++;
          $display("FAIL single_bit_accept: in_port=%h rise=%h, expected 00000001 00000001",
                   bus.in_port, bus.rise);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int rise5;
    rise5 = 0;
    bus.raw_in = 32'h21;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL glitch cycle %0d: in_port=%h rise=%h fall=%h tick=%b, expected %h %h %h %b",
                 k, bus.in_port, bus.rise, bus.fall, bus.sample_tick, m_in, m_rise, m_fall, exp_tick());
      end
      if (bus.rise[5]) rise5++;
      if (k == 5) bus.raw_in = 32'h1;
    end
    checks++;
    if (bus.in_port !== 32'h1 || rise5 != 0) begin
      errors++;
      $display("FAIL glitch_filtered: in_port=%h rise5_pulses=%0d, expected 00000001 0", bus.in_port, rise5);
    end
  endtask

  task automatic test_all_bits();
    int pulses;
    bit exact;
    pulses = 0;
    exact = 0;
    bus.raw_in = 32'hFFFF0000;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL all_bits cycle %0d: in_port=%h rise=%h fall=%h tick=%b, expected %h %h %h %b",
                 k, bus.in_port, bus.rise, bus.fall, bus.sample_tick, m_in, m_rise, m_fall, exp_tick());
      end
      if (k == 29) begin
        checks++;
        if (bus.in_port !== 32'hFFFF0000) begin
          errors++;
          $display("FAIL all_bits_settle: in_port=%h, expected ffff0000", bus.in_port);
        end
        bus.raw_in = 32'h0000FFFF;
      end
      if (k >= 30 && (bus.rise != 0 || bus.fall != 0)) begin
        pulses++;
        if (bus.rise === 32'h0000FFFF && bus.fall === 32'hFFFF0000) exact = 1;
      end
    end
    checks++;
    if (pulses != 1 || !exact || bus.in_port !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL all_bits_swap: pulse_cycles=%0d exact=%0d in_port=%h, expected 1 1 0000ffff",
               pulses, exact, bus.in_port);
    end
  endtask

  task automatic test_enable_freeze();
    int diff, off_ticks, on_ticks;
    bit seen;
    diff = 0; off_ticks = 0; on_ticks = 0; seen = 0;
    bus.enable = 1'b1;
    bus.raw_in = 32'h0;
    for (int k = 0; k < 30; k++) @(negedge clk);
    bus.raw_in = 32'h1;
    for (int k = 0; k < 40 && diff < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL enable_pre cycle %0d: in_port=%h tick=%b, expected %h %b",
                 k, bus.in_port, bus.sample_tick, m_in, exp_tick());
      end
      if (exp_tick() && m_s2[0] !== m_in[0]) diff++;
    end
    @(negedge clk);
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL enable_off cycle %0d: in_port=%h rise=%h tick=%b, expected %h %h %b",
                 k, bus.in_port, bus.rise, bus.sample_tick, m_in, m_rise, exp_tick());
      end
      if (bus.sample_tick) off_ticks++;
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL enable_on cycle %0d: in_port=%h rise=%h tick=%b, expected %h %h %b",
                 k, bus.in_port, bus.rise, bus.sample_tick, m_in, m_rise, exp_tick());
      end
      if (bus.rise[0]) seen = 1;
      else if (bus.sample_tick) on_ticks++;
    end
    checks++;
    if (diff != 2 || off_ticks != 0 || !seen || on_ticks != 1) begin
      errors++;
      $display("FAIL enable_freeze: diff_ticks=%0d off_ticks=%0d rise_seen=%0d ticks_to_rise=%0d, expected 2 0 1 1",
               diff, off_ticks, seen, on_ticks);
    end
  endtask

  task automatic test_reset_mid();
    int diff, ticks;
    bit seen;
    diff = 0; ticks = 0; seen = 0;
    bus.enable = 1'b1;
    bus.raw_in = 32'h0;
    for (int k = 0; k < 30; k++) @(negedge clk);
    bus.raw_in = 32'h1;
    for (int k = 0; k < 40 && diff < 2; k++) begin
      @(negedge clk);
      if (exp_tick() && m_s2[0] !== m_in[0]) diff++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== '0 || diff != 2) begin
      errors++;
      $display("FAIL reset_mid_clear: in_port=%h rise=%h fall=%h tick=%b diff_ticks=%0d, expected all 0 and 2",
               bus.in_port, bus.rise, bus.fall, bus.sample_tick, diff);
    end
    reset = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: in_port=%h rise=%h tick=%b, expected %h %h %b",
                 k, bus.in_port, bus.rise, bus.sample_tick, m_in, m_rise, exp_tick());
      end
      if (bus.rise[0]) seen = 1;
      else if (bus.sample_tick) ticks++;
    end
    checks++;
    if (!seen || ticks != 3 || bus.in_port !== 32'h1) begin
      errors++;
      $display("FAIL reset_mid_refilter: rise_seen=%0d ticks=%0d in_port=%h, expected 1 3 00000001",
               seen, ticks, bus.in_port);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_port, bus.rise, bus.fall, bus.sample_tick} !== {m_in, m_rise, m_fall, exp_tick()}) begin
        errors++;
        $display("FAIL random cycle %0d: in_port=%h rise=%h fall=%h tick=%b, expected %h %h %h %b",
                 k, bus.in_port, bus.rise, bus.fall, bus.sample_tick, m_in, m_rise, m_fall, exp_tick());
      end
      reset = ($urandom_range(0, 249) == 0);
      if (hold == 0) begin
        bus.raw_in = bus.raw_in ^ ($urandom & $urandom);
        bus.enable = ($urandom_range(0, 5) != 0);
        hold = $urandom_range(1, 24);
      end else begin
        hold--;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.raw_in = '0;
    test_reset();
    test_single_bit();
    test_glitch();
    test_all_bits();
    test_enable_freeze();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
